// File: rtl/montgomery_mmm_stream.sv
// montgomery_mmm_stream
//
// Radix-2 bit-serial Montgomery modular multiplier with valid/ready handshakes.
// Computes P = A * B * 2^(-K_BITS) mod m. One bit of A is consumed per CALC
// cycle. A single conditional subtraction in CORR produces a fully reduced result.
// An even modulus skips the computation. It completes at once with o_Err set and
// a zero result.
//
// Parameters:
//   K_BITS    operand / modulus width (>= 2)
//   CNT_W     iteration counter width, derived from K_BITS
//
// Ports:
//   i_Clk      clock
//   i_Rst      asynchronous active-high reset
//   i_Valid    operand set on i_A / i_B / i_m is valid
//   o_Ready    block can accept operands (high only in IDLE)
//   i_A        multiplier, expected < m
//   i_B        multiplicand, expected < m
//   i_m        modulus, expected odd
//   o_P_final  result, stable while o_Done is high
//   o_Done     result valid, held until i_Ready
//   i_Ready    consumer accepts the result
//   o_Err      qualifies o_Done: captured modulus was even
module montgomery_mmm_stream #(
  parameter int unsigned K_BITS = 8,
  parameter int unsigned CNT_W  = $clog2(K_BITS)
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic              i_Valid,
  output logic              o_Ready,
  input  logic [K_BITS-1:0] i_A,
  input  logic [K_BITS-1:0] i_B,
  input  logic [K_BITS-1:0] i_m,
  output logic [K_BITS-1:0] o_P_final,
  output logic              o_Done,
  input  logic              i_Ready,
  output logic              o_Err
);

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StCorr,
    StDone
  } state_e;

  state_e            state_q;
  logic [K_BITS-1:0] a_q;       // shifted right each iteration, LSB is the active bit
  logic [K_BITS-1:0] b_q;
  logic [K_BITS-1:0] m_q;
  logic [K_BITS:0]   p_q;       // one extra bit: P < 2m between iterations
  logic [CNT_W-1:0]  cnt_q;
  logic [K_BITS-1:0] result_q;
  logic              done_q;
  logic              err_q;
  logic              ready_q;

  // One Montgomery step. tau < 3m and Z < 4m, so K_BITS+2 bits hold both
  // without truncation before the shift.
  logic [K_BITS+1:0] tau;
  logic [K_BITS+1:0] z;
  logic [K_BITS:0]   p_next;
  logic              unused_z0;  // Z is always even, its LSB carries nothing

  always_comb begin
    tau    = {1'b0, p_q} + (a_q[0] ? {2'b00, b_q} : '0);
    z      = tau + (tau[0] ? {2'b00, m_q} : '0);
    p_next = z[K_BITS+1:1];
  end

  assign unused_z0 = z[0];

  // Final reduction. P < 2m, so one subtraction suffices and the reduced value
  // fits in K_BITS. The K_BITS-wide difference is therefore exact.
  logic              p_ge_m;
  logic [K_BITS-1:0] p_red;
  logic [K_BITS-1:0] p_corr;

  always_comb begin
    p_ge_m = (p_q >= {1'b0, m_q});
    p_red  = p_q[K_BITS-1:0] - m_q;
    p_corr = p_ge_m ? p_red : p_q[K_BITS-1:0];
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      m_q      <= '0;
      p_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (i_Valid) begin
            ready_q <= 1'b0;
            if (i_m[0]) begin
              a_q     <= i_A;
              b_q     <= i_B;
              m_q     <= i_m;
              p_q     <= '0;
              cnt_q   <= '0;
              state_q <= StCalc;
            end else begin
              // An even modulus has no inverse of 2. Report the error immediately.
              result_q <= '0;
              err_q    <= 1'b1;
              done_q   <= 1'b1;
              state_q  <= StDone;
            end
          end
        end

        StCalc: begin
          p_q <= p_next;
          a_q <= a_q >> 1;
          // The counter parks at its terminal value instead of wrapping.
          if (cnt_q == CNT_W'(K_BITS - 1)) begin
            state_q <= StCorr;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        StCorr: begin
          p_q      <= {1'b0, p_corr};
          result_q <= p_corr;
          err_q    <= 1'b0;
          done_q   <= 1'b1;
          state_q  <= StDone;
        end

        StDone: begin
          if (i_Ready) begin
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ready_q <= 1'b1;
            state_q <= StIdle;
          end
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign o_Ready   = ready_q;
  assign o_Done    = done_q;
  assign o_Err     = err_q;
  assign o_P_final = result_q;

endmodule
